// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - 2-flop synchroniser plus per-bit stability-counter debouncer for slide switches
// Optional sticky change interrupt (irq/irq_ack) built only with SWITCH_CHANGE_IRQ_EN defined.
module switch_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_changed
`ifdef SWITCH_CHANGE_IRQ_EN
    ,
    output logic             irq,
    input  logic             irq_ack
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] clean_q, clean_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Any sample matching the settled level restarts that bit's count from zero.
    always_comb begin
        clean_d   = clean_q;
        changed_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    clean_d[i]   = s2_q[i];
                    changed_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            clean_q   <= '0;
            changed_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= sw_raw;
            s2_q      <= s1_q;
            clean_q   <= clean_d;
            changed_q <= changed_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_clean   = clean_q;
    assign sw_changed = changed_q;

`ifdef SWITCH_CHANGE_IRQ_EN
    logic irq_q, irq_d;

    // A new change outranks a simultaneous acknowledge so no event is lost.
    always_comb begin
        irq_d = irq_q;
        if (|changed_q) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - randomized and directed bench for switch_debounce against a sample-window model
module tb_switch_debounce;

    localparam int D = 4;

    logic       clk;
    logic       reset_n;
    logic [7:0] sw_raw;
    logic [7:0] sw_clean;
    logic [7:0] sw_changed;
    logic       irq_ack;
`ifdef SWITCH_CHANGE_IRQ_EN
    logic       irq;
`endif

    int vectors = 0;
    int errors  = 0;

    logic [7:0] exp_clean;
    logic [7:0] exp_changed;
    logic       exp_irq;
    logic [7:0] hist[$];

    switch_debounce #(
        .WIDTH(8),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sw_raw(sw_raw),
        .sw_clean(sw_clean),
        .sw_changed(sw_changed)
`ifdef SWITCH_CHANGE_IRQ_EN
        ,
        .irq(irq),
        .irq_ack(irq_ack)
`endif
    );

    always #5 clk = ~clk;

    // Model: hist[k] is the raw value sampled k edges ago; the debouncer sees
    // the value from two edges back, and a bit flips once its last D seen
    // samples all differ from the current clean level.
    task automatic model_reset();
        exp_clean   = '0;
        exp_changed = '0;
        exp_irq     = 1'b0;
        hist.delete();
        for (int k = 0; k < D + 2; k++) hist.push_back(8'h00);
    endtask

    task automatic cycle(input logic [7:0] v);
        logic [7:0] h;
        logic       ok;
        sw_raw = v;
        @(posedge clk);
        if (|exp_changed) exp_irq = 1'b1;
        else if (irq_ack) exp_irq = 1'b0;
        hist.push_front(v);
        while (hist.size() > D + 2) void'(hist.pop_back());
        exp_changed = '0;
        for (int i = 0; i < 8; i++) begin
            ok = 1'b1;
            for (int j = 0; j < D; j++) begin
                h = hist[2 + j];
                if (h[i] == exp_clean[i]) ok = 1'b0;
            end
            if (ok) begin
                exp_clean[i]   = ~exp_clean[i];
                exp_changed[i] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic settle(input logic [7:0] v);
        repeat (D + 4) cycle(v);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        model_reset();
        vectors++;
        if (sw_clean !== 8'h00 || sw_changed !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: clean=%h changed=%h required 00/00", sw_clean, sw_changed);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cycle(8'h00);
            vectors++;
            if (sw_clean !== 8'h00 || sw_changed !== 8'h00) begin
                errors++;
                $display("FAIL idle_zero edge %0d: clean=%h changed=%h required 00/00", k, sw_clean, sw_changed);
            end
        end
    endtask

    task automatic test_step();
        for (int k = 1; k <= 8; k++) begin
            cycle(8'h01);
            vectors++;
            if (sw_clean !== ((k >= 6) ? 8'h01 : 8'h00) || sw_changed !== ((k == 6) ? 8'h01 : 8'h00)) begin
                errors++;
                $display("FAIL step edge %0d: clean=%h changed=%h required %h/%h", k, sw_clean, sw_changed,
                         (k >= 6) ? 8'h01 : 8'h00, (k == 6) ? 8'h01 : 8'h00);
            end
        end
    endtask

    task automatic test_bounce();
        settle(8'h00);
        for (int k = 1; k <= 10; k++) begin
            cycle((k == 2) ? 8'h00 : 8'h01);
            vectors++;
            if (sw_clean[0] !== (k >= 8) || sw_changed[0] !== (k == 8) || sw_clean !== exp_clean) begin
                errors++;
                $display("FAIL bounce edge %0d: clean=%h changed=%h required clean[0]=%0d changed[0]=%0d model=%h",
                         k, sw_clean, sw_changed, (k >= 8), (k == 8), exp_clean);
            end
        end
    endtask

    task automatic test_multi_bit();
        settle(8'h00);
        for (int k = 1; k <= 8; k++) begin
            cycle(8'hA5);
            vectors++;
            if (sw_clean !== ((k >= 6) ? 8'hA5 : 8'h00) || sw_changed !== ((k == 6) ? 8'hA5 : 8'h00)) begin
                errors++;
                $display("FAIL multi_bit edge %0d: clean=%h changed=%h required %h/%h", k, sw_clean, sw_changed,
                         (k >= 6) ? 8'hA5 : 8'h00, (k == 6) ? 8'hA5 : 8'h00);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        settle(8'h00);
        repeat (4) cycle(8'hFF);
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (sw_clean !== 8'h00 || sw_changed !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: clean=%h changed=%h required 00/00", sw_clean, sw_changed);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cycle(8'hFF);
            vectors++;
            if (sw_clean !== ((k >= 6) ? 8'hFF : 8'h00) || sw_changed !== ((k == 6) ? 8'hFF : 8'h00)) begin
                errors++;
                $display("FAIL reset_restart edge %0d: clean=%h changed=%h required %h/%h", k, sw_clean,
                         sw_changed, (k >= 6) ? 8'hFF : 8'h00, (k == 6) ? 8'hFF : 8'h00);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        v = sw_raw;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 5) == 0) v[i] = ~v[i];
            end
`ifdef SWITCH_CHANGE_IRQ_EN
            irq_ack = ($urandom_range(0, 7) == 0);
`endif
            cycle(v);
            vectors++;
            if (sw_clean !== exp_clean || sw_changed !== exp_changed) begin
                errors++;
                $display("FAIL random cycle %0d: clean=%h changed=%h required %h/%h", k, sw_clean, sw_changed,
                         exp_clean, exp_changed);
            end
`ifdef SWITCH_CHANGE_IRQ_EN
            vectors++;
            if (irq !== exp_irq) begin
                errors++;
                $display("FAIL random_irq cycle %0d: irq=%0d required %0d", k, irq, exp_irq);
            end
`endif
        end
        irq_ack = 1'b0;
    endtask

`ifdef SWITCH_CHANGE_IRQ_EN
    task automatic test_irq();
        settle(8'h00);
        irq_ack = 1'b1;
        cycle(8'h00);
        irq_ack = 1'b0;
        vectors++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear_initial: irq=%0d required 0", irq);
        end
        for (int k = 1; k <= 7; k++) begin
            cycle(8'h10);
            vectors++;
            if (irq !== (k >= 7) || irq !== exp_irq) begin
                errors++;
                $display("FAIL irq_set edge %0d: irq=%0d required %0d", k, irq, (k >= 7));
            end
        end
        repeat (6) cycle(8'h00);
        irq_ack = 1'b1;
        cycle(8'h00);
        irq_ack = 1'b0;
        vectors++;
        if (irq !== 1'b1 || irq !== exp_irq) begin
            errors++;
            $display("FAIL irq_set_wins: irq=%0d required 1", irq);
        end
        repeat (2) cycle(8'h00);
        irq_ack = 1'b1;
        cycle(8'h00);
        irq_ack = 1'b0;
        vectors++;
        if (irq !== 1'b0 || irq !== exp_irq) begin
            errors++;
            $display("FAIL irq_ack_clear: irq=%0d required 0", irq);
        end
    endtask
`endif

    initial begin
        clk     = 1'b0;
        reset_n = 1'b0;
        sw_raw  = 8'h00;
        irq_ack = 1'b0;
        model_reset();
        test_reset();
        test_step();
        test_bounce();
        test_multi_bit();
        test_reset_mid_count();
`ifdef SWITCH_CHANGE_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
